// File: rtl/matrix_link_coordinator.sv
// rtl/matrix_link_coordinator.sv - UART-side coordinator: command parse, operand load, engine start, result send
//
// Purpose: receives a command byte, deserialises operand matrices (little-endian,
// BYTES bytes per WIDTH-bit word) into internal buffers, kicks the matrix engine,
// then serialises either the result buffer (B) or operand 0 (L) back out.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   received_byte/_ready  UART receiver byte + one-cycle valid strobe
//   transmit_byte/_ready  byte offered to the UART transmitter
//   transmit_available    transmitter accepts; transfer when ready & available
//   engine_start          one-cycle pulse once all operands are loaded
//   engine_done           one-cycle pulse from the engine, result complete
//   engine_op_sel/_addr   operand read select; engine_rdata is combinational
//   result_we/_addr/_wdata result buffer write port (accepted in any state)
//   green_leds            [2:0] state code, [6] bad command, [7] receive overrun
module matrix_link_coordinator #(
  parameter int         DIM       = 2,
  parameter int         WIDTH     = 37,
  parameter int         NUM_OPS   = 2,
  parameter logic [7:0] CMD_BENCH = 8'h42,
  parameter logic [7:0] CMD_LOOP  = 8'h4C,
  localparam int        ELEMS     = 2 * DIM * DIM,
  localparam int        OPW       = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
  localparam int        AW        = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       received_byte,
  input  logic             received_ready,
  output logic [7:0]       transmit_byte,
  output logic             transmit_ready,
  input  logic             transmit_available,
  output logic             engine_start,
  input  logic             engine_done,
  input  logic [OPW-1:0]   engine_op_sel,
  input  logic [AW-1:0]    engine_addr,
  output logic [WIDTH-1:0] engine_rdata,
  input  logic             result_we,
  input  logic [AW-1:0]    result_addr,
  input  logic [WIDTH-1:0] result_wdata,
  output logic [7:0]       green_leds
);

  localparam int BYTES = (WIDTH + 7) / 8;
  localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int XW    = BYTES * 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  logic [2:0]       r_state;
  logic             r_loop;
  logic             r_src_res;
  logic             r_bad;
  logic             r_ovr;
  logic [BIW-1:0]   r_byte_idx;
  logic [AW-1:0]    r_elem;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_op_buf [NUM_OPS][ELEMS];
  logic [WIDTH-1:0] r_res_buf [ELEMS];

  logic             w_last_byte;
  logic             w_last_elem;
  logic             w_last_op;
  logic             w_elem_done;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_tx_word;
  logic [XW-1:0]    w_tx_ext;

  assign w_last_byte = (r_byte_idx == BIW'(BYTES - 1));
  assign w_last_elem = (r_elem == AW'(ELEMS - 1));
  // Loopback only ever fills operand 0, so its first matrix is also its last.
  assign w_last_op   = r_loop | (r_op == OPW'(NUM_OPS - 1));
  assign w_elem_done = received_ready && (r_state == S_RECV) && w_last_byte;

  // Accumulator with the incoming byte merged in at its lane; bits of the last
  // byte that fall above WIDTH simply have no destination and are dropped.
  always_comb begin
    w_word = r_acc;
    for (int i = 0; i < WIDTH; i++) begin
      if (BIW'(i / 8) == r_byte_idx) w_word[i] = received_byte[i % 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_loop     <= 1'b0;
      r_src_res  <= 1'b0;
      r_bad      <= 1'b0;
      r_ovr      <= 1'b0;
      r_byte_idx <= '0;
      r_elem     <= '0;
      r_op       <= '0;
      r_acc      <= '0;
    end else begin
      if (received_ready && (r_state == S_START || r_state == S_WAIT || r_state == S_SEND))
        r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (received_ready) begin
            if (received_byte == CMD_BENCH) begin
              r_state <= S_RECV;
              r_loop  <= 1'b0;
            end else if (received_byte == CMD_LOOP) begin
              r_state <= S_RECV;
              r_loop  <= 1'b1;
            end else begin
              r_bad <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (received_ready) begin
            r_acc <= w_word;
            if (w_last_byte) begin
              r_byte_idx <= '0;
              if (w_last_elem) begin
                r_elem <= '0;
                if (w_last_op) begin
                  r_op      <= '0;
                  r_src_res <= 1'b0;
                  r_state   <= r_loop ? S_SEND : S_START;
                end else begin
                  r_op <= r_op + 1'b1;
                end
              end else begin
                r_elem <= r_elem + 1'b1;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (engine_done) begin
            r_state   <= S_SEND;
            r_src_res <= 1'b1;
          end
        end
        S_SEND: begin
          if (transmit_available) begin
            if (w_last_byte) begin
              r_byte_idx <= '0;
              if (w_last_elem) begin
                r_elem  <= '0;
                r_state <= S_IDLE;
              end else begin
                r_elem <= r_elem + 1'b1;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffers carry no reset; writes are gated by state so a reset mid-frame
  // cannot land a partial word.
  always_ff @(posedge clk) begin
    if (w_elem_done) r_op_buf[r_op][r_elem] <= w_word;
    if (result_we && (int'(result_addr) < ELEMS)) r_res_buf[result_addr] <= result_wdata;
  end

  assign w_tx_word = r_src_res ? r_res_buf[r_elem] : r_op_buf[0][r_elem];

  for (genvar gi = 0; gi < XW; gi++) begin : g_sext
    if (gi < WIDTH) begin : g_bit
      assign w_tx_ext[gi] = w_tx_word[gi];
    end else begin : g_sign
      assign w_tx_ext[gi] = w_tx_word[WIDTH-1];
    end
  end

  assign transmit_ready = (r_state == S_SEND);
  assign transmit_byte  = transmit_ready ? w_tx_ext[{r_byte_idx, 3'b000} +: 8] : 8'h00;
  assign engine_start   = (r_state == S_START);
  assign green_leds     = {r_ovr, r_bad, 3'b000, r_state};
  assign engine_rdata   = ((int'(engine_op_sel) < NUM_OPS) && (int'(engine_addr) < ELEMS))
                          ? r_op_buf[engine_op_sel][engine_addr] : '0;

endmodule

// File: tb/tb_matrix_link_coordinator.sv
// tb/tb_matrix_link_coordinator.sv - self-checking bench for matrix_link_coordinator (default and swept parameters)
module tb_matrix_link_coordinator;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Default instance: DIM=2, WIDTH=37, NUM_OPS=2
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        tx_avail;
  logic        eng_start;
  logic        eng_done;
  logic [0:0]  op_sel;
  logic [2:0]  eng_addr;
  logic [36:0] rdata;
  logic        res_we;
  logic [2:0]  res_addr;
  logic [36:0] res_wdata;
  logic [7:0]  leds;

  // Swept instance: DIM=3, WIDTH=16, NUM_OPS=3
  logic [7:0]  s_rx_byte;
  logic        s_rx_ready;
  logic [7:0]  s_tx;
  logic        s_ready;
  logic        s_avail;
  logic        s_start;
  logic        s_done;
  logic [1:0]  s_op_sel;
  logic [4:0]  s_addr;
  logic [15:0] s_rdata;
  logic        s_we;
  logic [4:0]  s_waddr;
  logic [15:0] s_wdata;
  logic [7:0]  s_leds;

  matrix_link_coordinator u_dut (
    .clk(clk), .reset(reset),
    .received_byte(rx_byte), .received_ready(rx_ready),
    .transmit_byte(tx_byte), .transmit_ready(tx_ready), .transmit_available(tx_avail),
    .engine_start(eng_start), .engine_done(eng_done),
    .engine_op_sel(op_sel), .engine_addr(eng_addr), .engine_rdata(rdata),
    .result_we(res_we), .result_addr(res_addr), .result_wdata(res_wdata),
    .green_leds(leds)
  );

  matrix_link_coordinator #(.DIM(3), .WIDTH(16), .NUM_OPS(3)) u_sweep (
    .clk(clk), .reset(reset),
    .received_byte(s_rx_byte), .received_ready(s_rx_ready),
    .transmit_byte(s_tx), .transmit_ready(s_ready), .transmit_available(s_avail),
    .engine_start(s_start), .engine_done(s_done),
    .engine_op_sel(s_op_sel), .engine_addr(s_addr), .engine_rdata(s_rdata),
    .result_we(s_we), .result_addr(s_waddr), .result_wdata(s_wdata),
    .green_leds(s_leds)
  );

  int n_chk;
  int n_fail;

  logic [39:0] cur [8];
  logic [39:0] opv [2][8];
  logic [36:0] resv [8];
  logic [15:0] sv [3][18];
  logic [15:0] sres [18];
  logic [7:0]  rx_q [$];
  logic [7:0]  s_q [$];
  logic [7:0]  first_exp [5];
  logic [7:0]  neg_exp [5];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a 37-bit word sign-extended to five bytes, byte k little-endian.
  function automatic logic [7:0] ext37(input logic [36:0] v, input int k);
    logic signed [63:0] s;
    s = 64'(signed'(v));
    return 8'((s >>> (8 * k)) & 64'hFF);
  endfunction

  task automatic strobe(input logic [7:0] b);
    rx_byte  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic s_strobe(input logic [7:0] b);
    s_rx_byte  = b;
    s_rx_ready = 1'b1;
    @(negedge clk);
    s_rx_ready = 1'b0;
  endtask

  // Collect n transmitted bytes; with bp set, availability toggles each cycle
  // and a stalled byte must stay put until it is taken.
  task automatic collect(input int n, input bit bp);
    int cyc;
    logic [7:0] held;
    bit stalled;
    rx_q.delete();
    stalled = 1'b0;
    held = 8'h00;
    cyc = 0;
    while (rx_q.size() < n && cyc < 4000) begin
      tx_avail = bp ? cyc[0] : 1'b1;
      if (tx_ready) begin
        if (stalled) chk("tx_hold", 64'(tx_byte), 64'(held));
        if (tx_avail) begin
          rx_q.push_back(tx_byte);
          stalled = 1'b0;
        end else begin
          held = tx_byte;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    tx_avail = 1'b0;
    chk("tx_count", 64'(rx_q.size()), 64'(n));
  endtask

  task automatic s_collect(input int n);
    int cyc;
    s_q.delete();
    cyc = 0;
    s_avail = 1'b1;
    while (s_q.size() < n && cyc < 4000) begin
      if (s_ready) s_q.push_back(s_tx);
      @(negedge clk);
      cyc++;
    end
    s_avail = 1'b0;
    chk("s_tx_count", 64'(s_q.size()), 64'(n));
  endtask

  task automatic do_loop(input bit bp);
    strobe(8'h4C);
    for (int e = 0; e < 8; e++)
      for (int k = 0; k < 5; k++) strobe(cur[e][8*k +: 8]);
    chk("loop_send_state", 64'(leds[2:0]), 64'd4);
    chk("loop_send_ready", 64'(tx_ready), 64'd1);
    collect(40, bp);
    for (int e = 0; e < 8; e++)
      for (int k = 0; k < 5; k++) chk("echo_byte", 64'(rx_q[e*5+k]), 64'(ext37(cur[e][36:0], k)));
    chk("loop_end_ready", 64'(tx_ready), 64'd0);
    chk("loop_end_state", 64'(leds[2:0]), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    rx_byte = 8'h00; rx_ready = 1'b0; tx_avail = 1'b0; eng_done = 1'b0;
    op_sel = '0; eng_addr = '0; res_we = 1'b0; res_addr = '0; res_wdata = '0;
    s_rx_byte = 8'h00; s_rx_ready = 1'b0; s_avail = 1'b0; s_done = 1'b0;
    s_op_sel = '0; s_addr = '0; s_we = 1'b0; s_waddr = '0; s_wdata = '0;
    first_exp = '{8'hA0, 8'h99, 8'h27, 8'hA8, 8'h05};
    neg_exp   = '{8'h5D, 8'h66, 8'hD8, 8'h57, 8'hFA};
    repeat (3) @(negedge clk);

    chk("rst_tx_ready", 64'(tx_ready), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'd0);
    chk("rst_engine_start", 64'(eng_start), 64'd0);
    chk("rst_leds", 64'(leds), 64'd0);
    chk("rst_sweep_leds", 64'(s_leds), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Loopback with the documented echo values
    cur = '{40'd24296004000, 40'd0, 40'd24296004001, 40'd0,
            40'd24296004002, 40'd0, 40'd0 - 40'd24296004003, 40'd0};
    do_loop(1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("echo_first_elem", 64'(rx_q[k]), 64'(first_exp[k]));
      chk("echo_neg_elem", 64'(rx_q[30+k]), 64'(neg_exp[k]));
      chk("echo_zero_elem", 64'(rx_q[5+k]), 64'd0);
    end

    // Bad command in IDLE
    strobe(8'h58);
    chk("bad_cmd_led", 64'(leds[6]), 64'd1);
    chk("bad_cmd_state", 64'(leds[2:0]), 64'd0);
    chk("bad_cmd_no_ovr", 64'(leds[7]), 64'd0);

    // Benchmark flow with random operands
    strobe(8'h42);
    for (int o = 0; o < 2; o++)
      for (int e = 0; e < 8; e++) begin
        opv[o][e] = 40'({$urandom, $urandom});
        if (o == 1 && e == 6) opv[o][e] = 40'hFA57D8665D;
        for (int k = 0; k < 5; k++) strobe(opv[o][e][8*k +: 8]);
      end
    chk("engine_start_pulse", 64'(eng_start), 64'd1);
    chk("start_state", 64'(leds[2:0]), 64'd2);
    @(negedge clk);
    chk("engine_start_single", 64'(eng_start), 64'd0);
    chk("wait_state", 64'(leds[2:0]), 64'd3);
    for (int o = 0; o < 2; o++)
      for (int e = 0; e < 8; e++) begin
        op_sel = 1'(o);
        eng_addr = 3'(e);
        #1;
        chk("operand_rdata", 64'(rdata), 64'(opv[o][e][36:0]));
      end
    op_sel = 1'b1;
    eng_addr = 3'd6;
    #1;
    chk("operand_rdata_const", 64'(rdata), 64'h1A57D8665D);

    // Overrun while waiting for the engine
    @(negedge clk);
    strobe(8'h55);
    chk("overrun_led", 64'(leds[7]), 64'd1);
    chk("overrun_state", 64'(leds[2:0]), 64'd3);
    for (int o = 0; o < 2; o++)
      for (int e = 0; e < 8; e++) begin
        op_sel = 1'(o);
        eng_addr = 3'(e);
        #1;
        chk("operand_after_overrun", 64'(rdata), 64'(opv[o][e][36:0]));
      end

    // Engine writes results; done coincides with the final write
    @(negedge clk);
    for (int e = 0; e < 8; e++) begin
      resv[e] = 37'({$urandom, $urandom});
      res_we = 1'b1;
      res_addr = 3'(e);
      res_wdata = resv[e];
      eng_done = (e == 7);
      @(negedge clk);
    end
    res_we = 1'b0;
    eng_done = 1'b0;
    chk("bench_send_state", 64'(leds[2:0]), 64'd4);
    collect(40, 1'b1);
    for (int e = 0; e < 8; e++)
      for (int k = 0; k < 5; k++) chk("result_byte", 64'(rx_q[e*5+k]), 64'(ext37(resv[e], k)));
    chk("bench_end_ready", 64'(tx_ready), 64'd0);
    chk("bench_end_state", 64'(leds[2:0]), 64'd0);

    // Reset in the middle of a benchmark frame
    strobe(8'h42);
    for (int i = 0; i < 13; i++) strobe(8'($urandom));
    chk("mid_recv_state", 64'(leds[2:0]), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_tx_ready", 64'(tx_ready), 64'd0);
    chk("midrst_tx_byte", 64'(tx_byte), 64'd0);
    chk("midrst_engine_start", 64'(eng_start), 64'd0);
    chk("midrst_leds", 64'(leds), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int e = 0; e < 8; e++) cur[e] = 40'({$urandom, $urandom});
    do_loop(1'b0);

    // Swept parameters: 108 operand bytes in, 36 result bytes out
    s_strobe(8'h42);
    for (int o = 0; o < 3; o++)
      for (int e = 0; e < 18; e++) begin
        sv[o][e] = 16'($urandom);
        s_strobe(sv[o][e][7:0]);
        s_strobe(sv[o][e][15:8]);
      end
    chk("s_engine_start", 64'(s_start), 64'd1);
    @(negedge clk);
    chk("s_engine_start_single", 64'(s_start), 64'd0);
    chk("s_wait_state", 64'(s_leds[2:0]), 64'd3);
    s_op_sel = 2'd2;
    s_addr = 5'd17;
    #1;
    chk("s_rdata_last", 64'(s_rdata), 64'(sv[2][17]));
    s_op_sel = 2'd0;
    s_addr = 5'd0;
    #1;
    chk("s_rdata_first", 64'(s_rdata), 64'(sv[0][0]));
    @(negedge clk);
    for (int e = 0; e < 18; e++) begin
      sres[e] = (e == 0) ? 16'h8001 : 16'($urandom);
      s_we = 1'b1;
      s_waddr = 5'(e);
      s_wdata = sres[e];
      s_done = (e == 17);
      @(negedge clk);
    end
    s_we = 1'b0;
    s_done = 1'b0;
    s_collect(36);
    for (int e = 0; e < 18; e++) begin
      chk("s_result_lo", 64'(s_q[2*e]), 64'(sres[e] & 16'h00FF));
      chk("s_result_hi", 64'(s_q[2*e+1]), 64'(sres[e] >> 8));
    end
    chk("s_const_lo", 64'(s_q[0]), 64'h01);
    chk("s_const_hi", 64'(s_q[1]), 64'h80);
    chk("s_end_ready", 64'(s_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
